// File: rtl/rx_ring_logger_if.sv
// Byte-stream and display bundle between the UART receiver, the ring logger and the FND driver.
// The master drives the receive/control strobes; the slave (logger) drives the display and status.
interface rx_ring_logger_if #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 4
);
    logic               rx_done;
    logic [D_WIDTH-1:0] rx_data;
    logic               rd_mode;
    logic               rd_step;
    logic               clr;
    logic [D_WIDTH-1:0] fnd_data;
    logic               fnd_valid;
    logic [A_WIDTH:0]   count;
    logic               full;
    logic               empty;
    logic               ovf;

    modport master (
        output rx_done, rx_data, rd_mode, rd_step, clr,
        input  fnd_data, fnd_valid, count, full, empty, ovf
    );

    modport slave (
        input  rx_done, rx_data, rd_mode, rd_step, clr,
        output fnd_data, fnd_valid, count, full, empty, ovf
    );
endinterface

// File: rtl/rx_ring_logger.sv
// Circular byte logger on an inferred simple-dual-port RAM with live echo and
// step-through pop display; pops deliver to fnd_data two edges after the step.
module rx_ring_logger #(
    parameter int D_WIDTH   = 8,
    parameter int A_WIDTH   = 4,
    parameter int OVERWRITE = 0
) (
    input logic             clk,
    input logic             n_rst,
    rx_ring_logger_if.slave bus
);
    localparam logic [A_WIDTH:0]   FULL_CNT = {1'b1, {A_WIDTH{1'b0}}};
    localparam logic [A_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [A_WIDTH-1:0] PTR_ONE  = 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_LAT  = 2'd2;

    logic [D_WIDTH-1:0] mem [2**A_WIDTH];
    logic [D_WIDTH-1:0] rdata_q;

    logic [A_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [A_WIDTH:0]   count_q, count_d;
    logic [1:0]         state_q, state_d;
    logic               ovf_q, ovf_d;
    logic               fnd_valid_q, fnd_valid_d;
    logic [D_WIDTH-1:0] fnd_data_q, fnd_data_d;

    logic full, empty, pop_acc, wr_acc, wr_over;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A write into a full buffer is still accepted when a pop frees a slot at the same edge.
    assign pop_acc = !bus.clr && (state_q == S_IDLE) && bus.rd_mode && bus.rd_step && !empty;
    assign wr_acc  = !bus.clr && bus.rx_done && (!full || pop_acc || (OVERWRITE != 0));
    assign wr_over = wr_acc && full && !pop_acc;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        state_d     = state_q;
        ovf_d       = ovf_q;
        fnd_valid_d = 1'b0;
        fnd_data_d  = fnd_data_q;
        if (bus.clr) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            state_d    = S_IDLE;
            ovf_d      = 1'b0;
            fnd_data_d = '0;
        end else begin
            if (wr_acc)
                wptr_d = wptr_q + PTR_ONE;
            if (pop_acc || wr_over)
                rptr_d = rptr_q + PTR_ONE;
            case ({wr_acc && !wr_over, pop_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (bus.rx_done && full && !pop_acc)
                ovf_d = 1'b1;
            // A completing pop owns the display even if the switch went back to live mode.
            if (state_q == S_LAT) begin
                fnd_data_d  = rdata_q;
                fnd_valid_d = 1'b1;
            end else if (wr_acc && !bus.rd_mode) begin
                fnd_data_d = bus.rx_data;
            end
            case (state_q)
                S_IDLE:  state_d = pop_acc ? S_RD : S_IDLE;
                S_RD:    state_d = S_LAT;
                S_LAT:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The pop snapshots the oldest entry at acceptance, before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wptr_q] <= bus.rx_data;
        if (pop_acc)
            rdata_q <= mem[rptr_q];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            ovf_q       <= 1'b0;
            fnd_valid_q <= 1'b0;
            fnd_data_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            ovf_q       <= ovf_d;
            fnd_valid_q <= fnd_valid_d;
            fnd_data_q  <= fnd_data_d;
        end
    end

    assign bus.fnd_data  = fnd_data_q;
    assign bus.fnd_valid = fnd_valid_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_rx_ring_logger.sv
// Drives a drop-mode and an overwrite-mode logger with identical stimulus and checks both
// against a queue-based FIFO model; popped bytes are matched through a scoreboard.
module tb_rx_ring_logger;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic       rx_done_r = 1'b0;
    logic [7:0] rx_data_r = 8'h00;
    logic       rd_mode_r = 1'b0;
    logic       rd_step_r = 1'b0;
    logic       clr_r     = 1'b0;

    rx_ring_logger_if #(.D_WIDTH(8), .A_WIDTH(4)) bus0 ();
    rx_ring_logger_if #(.D_WIDTH(8), .A_WIDTH(4)) bus1 ();

    assign bus0.rx_done = rx_done_r;
    assign bus0.rx_data = rx_data_r;
    assign bus0.rd_mode = rd_mode_r;
    assign bus0.rd_step = rd_step_r;
    assign bus0.clr     = clr_r;
    assign bus1.rx_done = rx_done_r;
    assign bus1.rx_data = rx_data_r;
    assign bus1.rd_mode = rd_mode_r;
    assign bus1.rd_step = rd_step_r;
    assign bus1.clr     = clr_r;

    rx_ring_logger #(.D_WIDTH(8), .A_WIDTH(4), .OVERWRITE(0)) u_drop (
        .clk(clk), .n_rst(n_rst), .bus(bus0));
    rx_ring_logger #(.D_WIDTH(8), .A_WIDTH(4), .OVERWRITE(1)) u_over (
        .clk(clk), .n_rst(n_rst), .bus(bus1));

    int total = 0;
    int bad   = 0;

    // Reference model: index 0 drops when full, index 1 overwrites the oldest byte.
    logic [7:0] mq   [2][$];
    logic [7:0] expq [2][$];
    int         pend  [2] = '{0, 0};
    logic [7:0] pval  [2] = '{8'h00, 8'h00};
    logic       ovf_m [2] = '{1'b0, 1'b0};
    logic [7:0] fnd_m [2] = '{8'h00, 8'h00};
    logic       vld_m [2] = '{1'b0, 1'b0};

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=0x%0h want=0x%0h", nm, inst, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            vld_m[i] = 1'b0;
            if (!n_rst || clr_r) begin
                mq[i].delete();
                if (!n_rst) expq[i].delete();
                else if (pend[i] != 0) void'(expq[i].pop_back());
                pend[i]  = 0;
                ovf_m[i] = 1'b0;
                fnd_m[i] = 8'h00;
            end else begin
                int  sz;
                bit  do_pop, latch;
                sz     = mq[i].size();
                do_pop = rd_mode_r && rd_step_r && (pend[i] == 0) && (sz > 0);
                latch  = (pend[i] == 1);
                if (pend[i] > 0) pend[i]--;
                if (latch) begin
                    fnd_m[i] = pval[i];
                    vld_m[i] = 1'b1;
                end
                if (do_pop) begin
                    pval[i] = mq[i].pop_front();
                    expq[i].push_back(pval[i]);
                    pend[i] = 2;
                end
                if (rx_done_r) begin
                    if (sz < 16 || do_pop) begin
                        mq[i].push_back(rx_data_r);
                        if (!rd_mode_r && !latch) fnd_m[i] = rx_data_r;
                    end else if (i == 1) begin
                        void'(mq[i].pop_front());
                        mq[i].push_back(rx_data_r);
                        ovf_m[i] = 1'b1;
                        if (!rd_mode_r && !latch) fnd_m[i] = rx_data_r;
                    end else begin
                        ovf_m[i] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check_inst(input int i, input logic [7:0] fd, input logic fv,
                              input logic [4:0] cnt, input logic fu, input logic em,
                              input logic ov);
        chk("count", i, int'(cnt), mq[i].size());
        chk("full", i, int'(fu), int'(mq[i].size() == 16));
        chk("empty", i, int'(em), int'(mq[i].size() == 0));
        chk("ovf", i, int'(ov), int'(ovf_m[i]));
        chk("fnd_data", i, int'(fd), int'(fnd_m[i]));
        chk("fnd_valid", i, int'(fv), int'(vld_m[i]));
        if (fv) begin
            if (expq[i].size() == 0) chk("unexpected_pop", i, int'(fd), -1);
            else chk("pop_value", i, int'(fd), int'(expq[i].pop_front()));
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            check_inst(0, bus0.fnd_data, bus0.fnd_valid, bus0.count, bus0.full, bus0.empty, bus0.ovf);
            check_inst(1, bus1.fnd_data, bus1.fnd_valid, bus1.count, bus1.full, bus1.empty, bus1.ovf);
        end
    end

    task automatic tick(input logic m, input logic w, input logic [7:0] d,
                        input logic s, input logic c);
        @(negedge clk);
        rd_mode_r = m;
        rx_done_r = w;
        rx_data_r = d;
        rd_step_r = s;
        clr_r     = c;
    endtask

    task automatic idle(input int n, input logic m);
        repeat (n) tick(m, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] d, input logic m);
        tick(m, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        repeat (n) begin
            tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            idle(3, 1'b1);
        end
    endtask

    task automatic clear();
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(2, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic m;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        idle(2, 1'b1);

        // Step on an empty buffer does nothing.
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Basic store and step-through.
        wr(8'h11, 1'b1); wr(8'h22, 1'b1); wr(8'h33, 1'b1);
        pop_n(3);
        idle(2, 1'b1);

        // Fill past capacity: drop vs overwrite.
        for (int k = 0; k < 17; k++) wr(8'(k), 1'b1);
        idle(2, 1'b1);
        pop_n(16);
        clear();
        for (int k = 0; k < 18; k++) wr(8'(k), 1'b1);
        idle(2, 1'b1);
        pop_n(2);
        clear();

        // Pointer wrap-around.
        for (int k = 0; k < 10; k++) wr(8'(8'h40 + k), 1'b0);
        pop_n(10);
        for (int k = 0; k < 10; k++) wr(8'(8'h80 + k), 1'b0);
        pop_n(10);
        clear();

        // Concurrent write and pop at count 5, then full with pop, then write/pop while empty.
        for (int k = 0; k < 5; k++) wr(8'(8'hA0 + k), 1'b1);
        tick(1'b1, 1'b1, 8'hC5, 1'b1, 1'b0);
        idle(3, 1'b1);
        for (int k = 0; k < 12; k++) wr(8'(8'hB0 + k), 1'b1);
        tick(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
        idle(3, 1'b1);
        clear();
        tick(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Clear while a pop is in flight.
        wr(8'h77, 1'b1);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        clear();
        idle(3, 1'b1);

        // Switch back to live mode mid-pop while bytes keep arriving.
        wr(8'h61, 1'b1); wr(8'h62, 1'b1);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 8'hCC, 1'b0, 1'b0);
        idle(3, 1'b0);
        clear();

        // Randomized traffic.
        m = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) m = ~m;
            tick(m, ($urandom_range(0, 99) < 45), 8'($urandom),
                 ($urandom_range(0, 99) < 35), ($urandom_range(0, 199) == 0));
        end
        idle(6, 1'b1);

        chk("drain", 0, expq[0].size(), 0);
        chk("drain", 1, expq[1].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
